// File: rtl/des_pkg.sv
// DES constant tables, state encoding and the permutation / S-box helpers
// shared by the iterative engine and its round sub-module.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } des_state_t;

  // Tables use DES bit numbering: bit 1 is the most significant bit.
  localparam int IP [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                             62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                             57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                             61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                             38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                             36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                             34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
  localparam int E [48] = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13,
                            12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                            24,25,26,27,28,29, 28,29,30,31,32, 1};
  localparam int P [32] = '{16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
                             2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};
  localparam int PC1 [56] = '{57,49,41,33,25,17, 9,  1,58,50,42,34,26,18,
                              10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
                              63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
                              14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};
  localparam int PC2 [48] = '{14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8,
                              16, 7,27,20,13, 2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                              44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFT [1:16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  localparam int S1 [64] = '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
                             4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13};
  localparam int S2 [64] = '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
                             0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9};
  localparam int S3 [64] = '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
                             13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12};
  localparam int S4 [64] = '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
                             10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14};
  localparam int S5 [64] = '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
                             4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3};
  localparam int S6 [64] = '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
                             9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13};
  localparam int S7 [64] = '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
                             1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12};
  localparam int S8 [64] = '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
                             7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP[i])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = 56'd0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1[i])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = 48'd0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2[i])];
    return y;
  endfunction

  function automatic logic [3:0] sbox(input logic [2:0] idx, input logic [5:0] six);
    logic [5:0] a;
    logic [3:0] v;
    a = {six[5], six[0], six[4:1]};
    case (idx)
      3'd0:    v = 4'(S1[a]);
      3'd1:    v = 4'(S2[a]);
      3'd2:    v = 4'(S3[a]);
      3'd3:    v = 4'(S4[a]);
      3'd4:    v = 4'(S5[a]);
      3'd5:    v = 4'(S6[a]);
      3'd6:    v = 4'(S7[a]);
      3'd7:    v = 4'(S8[a]);
      default: v = 4'd0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] ex;
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    ex = 48'd0;
    for (int i = 0; i < 48; i++) ex[6'(47 - i)] = r[5'(32 - E[i])];
    x = ex ^ k;
    s = 32'd0;
    for (int b = 0; b < 8; b++) s[5'(31 - 4 * b) -: 4] = sbox(3'(b), x[6'(47 - 6 * b) -: 6]);
    y = 32'd0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P[i])];
    return y;
  endfunction

  // A valid DES key has odd parity in every byte.
  function automatic logic key_parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) ok = ok & (^k[6'(8 * b) +: 8]);
    return ok;
  endfunction

  // Decryption replays the schedule backwards: round 1 reuses C0/D0 unrotated.
  function automatic logic [1:0] shift_amt(input logic [4:0] rnd, input logic dec);
    logic [1:0] amt;
    if (rnd == 5'd0 || rnd > 5'd16) amt = 2'd0;
    else if (!dec) amt = 2'(SHIFT[rnd]);
    else if (rnd == 5'd1) amt = 2'd0;
    else amt = 2'(SHIFT[5'd18 - rnd]);
    return amt;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt, input logic right);
    logic [27:0] y;
    case ({right, amt})
      3'b001:  y = {x[26:0], x[27]};
      3'b010:  y = {x[25:0], x[27:26]};
      3'b101:  y = {x[0], x[27:1]};
      3'b110:  y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L ^ f(R, K).
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l_in,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic [31:0] l_out,
  output logic [31:0] r_out
);

  assign l_out = r_in;
  assign r_out = l_in ^ feistel(r_in, subkey);

endmodule

// File: rtl/des_iter_engine.sv
// Iterative DES encrypt/decrypt engine evaluating ROUNDS_PER_CYCLE rounds per
// clock, with a valid/ready request side and a valid/ready result side.
module des_iter_engine
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int KEY_PARITY_CHECK = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [64:1] msg,
  input  logic [64:1] key,
  input  logic        decrypt_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [64:1] data_out,
  output logic        key_err,
  output logic        busy
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
    $error("des_iter_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [4:0] RPC_STEP = 5'(ROUNDS_PER_CYCLE);

  des_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic        dec_q, dec_d;
  logic [63:0] data_out_q, data_out_d;
  logic        key_err_q, key_err_d;

  logic        accept_s;
  logic        key_bad_s;
  logic [31:0] l_s [ROUNDS_PER_CYCLE+1];
  logic [31:0] r_s [ROUNDS_PER_CYCLE+1];
  logic [27:0] c_s [ROUNDS_PER_CYCLE+1];
  logic [27:0] d_s [ROUNDS_PER_CYCLE+1];

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign key_bad_s = (KEY_PARITY_CHECK != 0) && !key_parity_ok(key);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign data_out  = data_out_q;
  assign key_err   = key_err_q;

  assign l_s[0] = l_q;
  assign r_s[0] = r_q;
  assign c_s[0] = c_q;
  assign d_s[0] = d_q;

  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
    logic [4:0]  rnd_s;
    logic [1:0]  amt_s;
    logic [47:0] subkey_s;

    // Key rotation for round j of this cycle, then its subkey.
    assign rnd_s      = cnt_q + 5'(j + 1);
    assign amt_s      = shift_amt(rnd_s, dec_q);
    assign c_s[j+1]   = rot28(c_s[j], amt_s, dec_q);
    assign d_s[j+1]   = rot28(d_s[j], amt_s, dec_q);
    assign subkey_s   = pc2_perm({c_s[j+1], d_s[j+1]});

    des_round u_round (
      .l_in   (l_s[j]),
      .r_in   (r_s[j]),
      .subkey (subkey_s),
      .l_out  (l_s[j+1]),
      .r_out  (r_s[j+1])
    );
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    l_d        = l_q;
    r_d        = r_q;
    c_d        = c_q;
    d_d        = d_q;
    dec_d      = dec_q;
    data_out_d = data_out_q;
    key_err_d  = key_err_q;
    case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        l_d   = l_s[ROUNDS_PER_CYCLE];
        r_d   = r_s[ROUNDS_PER_CYCLE];
        c_d   = c_s[ROUNDS_PER_CYCLE];
        d_d   = d_s[ROUNDS_PER_CYCLE];
        cnt_d = cnt_q + RPC_STEP;
        if (cnt_d >= 5'd16) begin
          cnt_d      = 5'd16;
          state_d    = DONE;
          data_out_d = fp_perm({r_s[ROUNDS_PER_CYCLE], l_s[ROUNDS_PER_CYCLE]});
          key_err_d  = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
        else state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // A new request overrides the hold/return decision above, giving back-to-back.
    if (accept_s) begin
      cnt_d      = 5'd0;
      dec_d      = decrypt_mode;
      {l_d, r_d} = ip_perm(msg);
      {c_d, d_d} = pc1_perm(key);
      if (key_bad_s) begin
        state_d    = DONE;
        data_out_d = 64'd0;
        key_err_d  = 1'b1;
      end else begin
        state_d   = RUN;
        key_err_d = 1'b0;
      end
    end else begin
      dec_d = dec_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      l_q        <= 32'd0;
      r_q        <= 32'd0;
      c_q        <= 28'd0;
      d_q        <= 28'd0;
      dec_q      <= 1'b0;
      data_out_q <= 64'd0;
      key_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      l_q        <= l_d;
      r_q        <= r_d;
      c_q        <= c_d;
      d_q        <= d_d;
      dec_q      <= dec_d;
      data_out_q <= data_out_d;
      key_err_q  <= key_err_d;
    end
  end

endmodule

// File: doc/des_iter_engine.md
DES_ITER_ENGINE -- requirements
Module: des_iter_engine

Interface
REQ-001 Parameter ROUNDS_PER_CYCLE, default 1: DES rounds evaluated per clock; legal values 1, 2, 4, 8, 16.
REQ-002 Parameter KEY_PARITY_CHECK, default 0: when 1, a key with any byte of even parity is rejected.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  a request is present on msg, key and decrypt_mode.
REQ-006 in_ready  output  1  the engine can accept a request this cycle.
REQ-007 msg  input  [64:1]  plaintext (encrypt) or ciphertext (decrypt); bit 1 is the LSB.
REQ-008 key  input  [64:1]  DES key, parity bits included.
REQ-009 decrypt_mode  input  1  0 = encrypt, 1 = decrypt; captured at acceptance.
REQ-010 out_valid  output  1  result is present on data_out.
REQ-011 out_ready  input  1  the consumer takes the result this cycle.
REQ-012 data_out  output  [64:1]  cipher (encrypt) or decrypt result (decrypt).
REQ-013 key_err  output  1  qualifies data_out: the key failed the parity check and data_out is all zeros.
REQ-014 busy  output  1  the engine is in state RUN.

Function
REQ-015 The engine SHALL have three states: IDLE, RUN and DONE.
REQ-016 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready).
REQ-017 Acceptance SHALL occur on a rising edge where in_valid and in_ready are both high, with these actions:
- load L/R from IP(msg) and C/D from PC1(key);
- latch decrypt_mode;
- clear the round counter;
- enter RUN.
REQ-018 Each RUN cycle SHALL apply ROUNDS_PER_CYCLE Feistel rounds and advance the round counter by ROUNDS_PER_CYCLE.
REQ-019 Encrypt round i SHALL left-rotate C and D by SHIFT[i], then use PC2(C,D) as the subkey.
REQ-020 Decrypt round 1 SHALL use PC2(C0,D0); each decrypt round i≥2 SHALL first right-rotate C and D by SHIFT[18-i].
REQ-021 On the edge completing round 16, the engine SHALL register data_out = FP(R16‖L16) and enter DONE with out_valid=1.
REQ-022 Latency SHALL be exactly 16/ROUNDS_PER_CYCLE edges from acceptance to out_valid high.
REQ-023 In DONE, data_out and key_err SHALL hold stable until out_valid && out_ready.
REQ-024 When the result is taken, the engine SHALL return to IDLE, or re-enter RUN if a new request is accepted on the same edge (back-to-back).
REQ-025 in_valid during RUN SHALL be ignored; the request is not lost, because in_ready is low.
REQ-026 With KEY_PARITY_CHECK=1 and a bad-parity key, the engine SHALL skip RUN and go directly to DONE on the edge after acceptance, with key_err=1 and data_out=0.
REQ-027 With KEY_PARITY_CHECK=0, key_err SHALL stay 0.
REQ-028 The round counter SHALL be 5 bits wide and SHALL never exceed 16.

Reset
REQ-029 Asserting reset SHALL immediately force:
- state IDLE;
- out_valid=0, busy=0, key_err=0;
- data_out=0, L/R/C/D=0, round counter=0.
REQ-030 in_ready SHALL read 1 while reset is deasserted and the engine is in IDLE.
REQ-031 Reset asserted during RUN or DONE SHALL discard the transaction with no partial output.
REQ-032 The first acceptance SHALL be possible on the first rising edge after reset deassertion.

Structure
REQ-033 Package des_pkg SHALL hold the tables IP, FP, E, P, PC1, PC2, S1–S8 and SHIFT[1:16], plus a des_state_t enum.
REQ-034 A combinational sub-module des_round (inputs L, R, subkey; outputs L', R') SHALL be instantiated ROUNDS_PER_CYCLE times.
REQ-035 The engine SHALL include a per-round key-rotation block alongside the des_round instances.
REQ-036 An illegal ROUNDS_PER_CYCLE value SHALL cause an elaboration-time error.

Verification
REQ-037 Encrypt test, all ROUNDS_PER_CYCLE values, key 133457799BBCDFF1, msg 0123456789ABCDEF -> data_out 85E813540F0AB405 after 16/ROUNDS_PER_CYCLE cycles.
REQ-038 Decrypt test, key 133457799BBCDFF1, msg 85E813540F0AB405, decrypt_mode=1 -> data_out 0123456789ABCDEF.
REQ-039 All-zero test, key 0000000000000000, msg 0000000000000000, encrypt -> data_out 8CA64DE9C1B123A7.
REQ-040 Back-pressure and back-to-back test:
- hold out_ready=0 for 5 cycles -> data_out stable, in_ready low;
- then raise out_ready with in_valid high -> new request accepted on the same edge.
REQ-041 Mid-operation reset test: assert reset on round 8 -> out_valid, busy and data_out go 0 immediately; the next request (vector of REQ-037) completes correctly.
REQ-042 Parity test with KEY_PARITY_CHECK=1, key 0000000000000000 -> key_err=1 and data_out=0 one cycle after acceptance.
